// File: rtl/xoodyak_pkg.sv
// Shared definitions for the Xoodyak digest collection path.
package xoodyak_pkg;

  localparam int DIGEST_BYTES_DEF = 32;
  localparam int HASH_BYTE_W      = 8;

  // Collector FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_COLLECT = 2'd2,
    ST_HOLD    = 2'd3
  } collector_state_e;

endpackage : xoodyak_pkg

// File: rtl/xoodyak_digest_cmp.sv
// Registered equality compare between the assembled digest and the reference.
// The result is loaded in the same cycle the final byte is written, so it lines
// up with digest_valid one clock later and stays frozen until the next load.
module xoodyak_digest_cmp #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load_i,
  input  logic [W-1:0] digest_i,
  input  logic [W-1:0] expected_i,
  output logic         match_o
);

  logic match_q;

  // Capture the compare result when the digest completes.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      match_q <= 1'b0;
    end else if (load_i) begin
      match_q <= (digest_i == expected_i);
    end
  end

  assign match_o = match_q;

endmodule : xoodyak_digest_cmp

// File: rtl/xoodyak_digest_collector.sv
// Collects the byte-serial squeeze output of the Xoodyak core into a full-width
// digest, hands it to the host over valid/ready and flags protocol errors.
module xoodyak_digest_collector
  import xoodyak_pkg::*;
#(
  parameter int DIGEST_BYTES = DIGEST_BYTES_DEF,
  parameter int CNT_W        = 7
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                core_start,
  input  logic [HASH_BYTE_W-1:0]              hash_byte,
  input  logic                                hash_valid,
  input  logic                                core_busy,
  input  logic [HASH_BYTE_W*DIGEST_BYTES-1:0] expected,
  output logic [HASH_BYTE_W*DIGEST_BYTES-1:0] digest,
  output logic                                digest_valid,
  input  logic                                digest_ready,
  output logic                                match,
  output logic [CNT_W-1:0]                    byte_cnt,
  output logic                                err_overrun,
  output logic                                err_short
);

  localparam int              DW       = HASH_BYTE_W * DIGEST_BYTES;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGEST_BYTES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DIGEST_BYTES);

  collector_state_e state_q, state_d;
  logic [DW-1:0]    digest_q, digest_d, wr_digest;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             pending_q, pending_d;
  logic             err_overrun_q, err_overrun_d;
  logic             err_short_q, err_short_d;
  logic             busy_q;
  logic             busy_fall;
  logic             last_byte;
  logic             cmp_load;

  assign busy_fall = busy_q & ~core_busy;
  assign last_byte = (byte_cnt_q == LAST_IDX);

  // Byte-lane write decoder: current digest with the lane at byte_cnt_q replaced.
  always_comb begin
    wr_digest = digest_q;
    for (int k = 0; k < DIGEST_BYTES; k++) begin
      if (byte_cnt_q == CNT_W'(k)) begin
        wr_digest[HASH_BYTE_W*k +: HASH_BYTE_W] = hash_byte;
      end
    end
  end

  // Next-state logic for the FSM, counter, pending start and error flags.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    digest_d      = digest_q;
    byte_cnt_d    = byte_cnt_q;
    pending_d     = pending_q;
    err_overrun_d = err_overrun_q;
    err_short_d   = err_short_q;
    cmp_load      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A byte here is dropped even if it coincides with the start pulse.
        if (hash_valid) err_overrun_d = 1'b1;
        if (core_start) begin
          state_d    = ST_ARMED;
          digest_d   = '0;
          byte_cnt_d = '0;
        end
      end

      ST_ARMED, ST_COLLECT: begin
        if (core_start) begin
          // Restart abandons the partial digest.
          state_d     = ST_ARMED;
          digest_d    = '0;
          byte_cnt_d  = '0;
          err_short_d = 1'b1;
        end else if (hash_valid && last_byte) begin
          state_d    = ST_HOLD;
          digest_d   = wr_digest;
          byte_cnt_d = FULL_CNT;
          cmp_load   = 1'b1;
        end else if (state_q == ST_COLLECT && busy_fall) begin
          state_d     = ST_IDLE;
          err_short_d = 1'b1;
        end else if (hash_valid) begin
          state_d    = ST_COLLECT;
          digest_d   = wr_digest;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        // The digest is frozen, so any byte arriving now is lost.
        if (hash_valid) err_overrun_d = 1'b1;
        if (digest_ready) begin
          pending_d = 1'b0;
          if (core_start || pending_q) begin
            state_d    = ST_ARMED;
            digest_d   = '0;
            byte_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (core_start) begin
          pending_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; everything clears asynchronously so a partial digest is discarded.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      // NOTE: the wide digest register is reset because its value is visible at the port.
      digest_q      <= '0;
      byte_cnt_q    <= '0;
      pending_q     <= 1'b0;
      err_overrun_q <= 1'b0;
      err_short_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      digest_q      <= digest_d;
      byte_cnt_q    <= byte_cnt_d;
      pending_q     <= pending_d;
      err_overrun_q <= err_overrun_d;
      err_short_q   <= err_short_d;
      busy_q        <= core_busy;
    end
  end

  xoodyak_digest_cmp #(
    .W (DW)
  ) u_cmp (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (cmp_load),
    .digest_i   (digest_d),
    .expected_i (expected),
    .match_o    (match)
  );

  assign digest       = digest_q;
  assign digest_valid = (state_q == ST_HOLD);
  assign byte_cnt     = byte_cnt_q;
  assign err_overrun  = err_overrun_q;
  assign err_short    = err_short_q;

endmodule : xoodyak_digest_collector

// File: tb/tb_xoodyak_digest_collector.sv
// Testbench for xoodyak_digest_collector with a digest scoreboard.
module tb_xoodyak_digest_collector;

  localparam int NB = 32;
  localparam int DW = 8 * NB;

  logic          clk = 1'b0;
  logic          resetn;
  logic          core_start;
  logic [7:0]    hash_byte;
  logic          hash_valid;
  logic          core_busy;
  logic [DW-1:0] expected;
  logic [DW-1:0] digest;
  logic          digest_valid;
  logic          digest_ready;
  logic          match;
  logic [6:0]    byte_cnt;
  logic          err_overrun;
  logic          err_short;

  xoodyak_digest_collector #(
    .DIGEST_BYTES (NB),
    .CNT_W        (7)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .core_start   (core_start),
    .hash_byte    (hash_byte),
    .hash_valid   (hash_valid),
    .core_busy    (core_busy),
    .expected     (expected),
    .digest       (digest),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .match        (match),
    .byte_cnt     (byte_cnt),
    .err_overrun  (err_overrun),
    .err_short    (err_short)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] digest;
    logic          match;
  } sb_t;

  typedef struct {
    logic [7:0] base;
    int         gap;
    int         flip;
    int         ready_delay;
  } vec_t;

  sb_t  sb_q[$];
  sb_t  cur_exp;
  vec_t vecs[5];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn       = 1'b0;
    core_start   = 1'b0;
    hash_byte    = 8'h00;
    hash_valid   = 1'b0;
    core_busy    = 1'b1;
    expected     = '0;
    digest_ready = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
  endtask

  // Drive one full digest; the model result goes onto the scoreboard first.
  task automatic run_digest(input logic [7:0] base, input int gap, input int flip, input bit do_start);
    logic [DW-1:0] dig;
    logic [DW-1:0] mask;
    dig  = '0;
    mask = '0;
    for (int k = 0; k < NB; k++) dig[8*k +: 8] = base + 8'(k);
    if (flip >= 0) mask[8*flip +: 8] = 8'hFF;
    expected       = dig ^ mask;
    cur_exp.digest = dig;
    cur_exp.match  = (flip < 0);
    sb_q.push_back(cur_exp);
    if (do_start) begin
      core_start = 1'b1;
      tick();
      core_start = 1'b0;
    end
    for (int k = 0; k < NB; k++) begin
      hash_valid = 1'b1;
      hash_byte  = base + 8'(k);
      tick();
      hash_valid = 1'b0;
      if (k == NB - 2) check("valid_early", digest_valid, 1'b0);
      if (k < NB - 1) repeat (gap) tick();
    end
    check("valid_latency", digest_valid, 1'b1);
    check("cnt_full", byte_cnt, 7'(NB));
  endtask

  // Hold ready low for a while, confirm the digest is frozen, then accept it.
  task automatic hold_and_accept(input int delay);
    digest_ready = 1'b0;
    for (int i = 0; i < delay; i++) begin
      check("hold_valid", digest_valid, 1'b1);
      check("hold_stable", digest, cur_exp.digest);
      tick();
    end
    digest_ready = 1'b1;
    tick();
    check("valid_drop", digest_valid, 1'b0);
    digest_ready = 1'b0;
  endtask

  // Scoreboard: compare every accepted digest against the oldest expected one.
  always @(negedge clk) begin
    if (resetn && digest_valid && digest_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 1'b1, 1'b0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("sb_digest", digest, e.digest);
        check("sb_match", match, e.match);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{base: 8'h00, gap: 0, flip: -1, ready_delay: 0};
    vecs[1] = '{base: 8'h00, gap: 2, flip: 5,  ready_delay: 10};
    vecs[2] = '{base: 8'h40, gap: 1, flip: -1, ready_delay: 3};
    vecs[3] = '{base: 8'hF0, gap: 0, flip: 31, ready_delay: 1};
    vecs[4] = '{base: 8'hC3, gap: 3, flip: 0,  ready_delay: 2};

    // Reset values.
    resetn = 1'b0;
    do_reset();
    check("rst_digest", digest, '0);
    check("rst_valid", digest_valid, 1'b0);
    check("rst_match", match, 1'b0);
    check("rst_cnt", byte_cnt, '0);
    check("rst_ovr", err_overrun, 1'b0);
    check("rst_short", err_short, 1'b0);

    // Table-driven digests.
    for (int v = 0; v < 5; v++) begin
      run_digest(vecs[v].base, vecs[v].gap, vecs[v].flip, 1'b1);
      if (v == 0) begin
        check("t1_byte0", digest[7:0], 8'h00);
        check("t1_byte31", digest[255:248], 8'h1F);
        check("t1_match", match, 1'b1);
      end
      hold_and_accept(vecs[v].ready_delay);
    end
    check("tbl_no_ovr", err_overrun, 1'b0);
    check("tbl_no_short", err_short, 1'b0);

    // Overrun in IDLE; the dropped byte must not appear in the next digest.
    do_reset();
    hash_valid = 1'b1;
    hash_byte  = 8'hAA;
    tick();
    hash_valid = 1'b0;
    check("ovr_set", err_overrun, 1'b1);
    check("ovr_cnt", byte_cnt, '0);
    run_digest(8'h10, 0, -1, 1'b1);
    check("ovr_byte0", digest[7:0], 8'h10);
    hold_and_accept(2);
    check("ovr_sticky", err_overrun, 1'b1);

    // Short digest: core goes idle after 20 bytes.
    do_reset();
    core_start = 1'b1;
    tick();
    core_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      hash_valid = 1'b1;
      hash_byte  = 8'(k);
      tick();
    end
    hash_valid = 1'b0;
    check("short_cnt20", byte_cnt, 7'd20);
    core_busy = 1'b0;
    tick();
    check("short_set", err_short, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("short_no_valid", digest_valid, 1'b0);
      tick();
    end
    hash_valid = 1'b1;
    tick();
    hash_valid = 1'b0;
    check("short_idle", err_overrun, 1'b1);
    core_busy = 1'b1;

    // Start during HOLD is remembered and re-arms after acceptance.
    do_reset();
    run_digest(8'h20, 0, -1, 1'b1);
    digest_ready = 1'b0;
    core_start   = 1'b1;
    tick();
    core_start = 1'b0;
    check("pend_hold", digest, cur_exp.digest);
    tick();
    tick();
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
    check("pend_drop", digest_valid, 1'b0);
    check("pend_cnt", byte_cnt, '0);
    run_digest(8'h80, 1, -1, 1'b0);
    hold_and_accept(0);
    check("pend_no_short", err_short, 1'b0);

    // Restart mid-collection, then overrun coinciding with a handshake.
    do_reset();
    core_start = 1'b1;
    tick();
    core_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      hash_valid = 1'b1;
      hash_byte  = 8'hE0;
      tick();
    end
    hash_valid = 1'b0;
    core_start = 1'b1;
    tick();
    core_start = 1'b0;
    check("rs_cnt", byte_cnt, '0);
    check("rs_short", err_short, 1'b1);
    run_digest(8'h90, 0, -1, 1'b0);
    digest_ready = 1'b1;
    hash_valid   = 1'b1;
    hash_byte    = 8'hEE;
    tick();
    hash_valid   = 1'b0;
    digest_ready = 1'b0;
    check("hs_ovr_valid", digest_valid, 1'b0);
    check("hs_ovr", err_overrun, 1'b1);

    // Reset mid-run discards the partial digest.
    do_reset();
    core_start = 1'b1;
    tick();
    core_start = 1'b0;
    for (int k = 0; k < 17; k++) begin
      hash_valid = 1'b1;
      hash_byte  = 8'h30 + 8'(k);
      tick();
    end
    hash_valid = 1'b0;
    resetn     = 1'b0;
    #2;
    check("mr_digest", digest, '0);
    check("mr_valid", digest_valid, 1'b0);
    check("mr_match", match, 1'b0);
    check("mr_cnt", byte_cnt, '0);
    check("mr_errs", {err_overrun, err_short}, 2'b00);
    tick();
    resetn = 1'b1;
    tick();
    check("mr_post_cnt", byte_cnt, '0);
    check("mr_post_valid", digest_valid, 1'b0);
    run_digest(8'h55, 0, -1, 1'b1);
    hold_and_accept(1);

    tick();
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_xoodyak_digest_collector
